// File: rtl/shift_normalizer.sv
// shift_normalizer: sequential normalizer that shifts a word until its target-end bit is set.
// Reports the normalized word and the shift count.
module shift_normalizer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] in_i,
    input  logic             dir_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] out_o,
    output logic [CNT_W-1:0] shift_o,
    output logic             zero_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d, out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, shift_q, shift_d;
    logic             dir_q, dir_d, zero_q, zero_d;
    logic             tgt;

    assign tgt = dir_q ? work_q[0] : work_q[WIDTH-1];

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        out_d   = out_q;
        shift_d = shift_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = RUN;
                work_d  = in_i;
                dir_d   = dir_i;
                cnt_d   = '0;
            end
            RUN: if (work_q == '0) begin
                state_d = DONE;
                out_d   = '0;
                shift_d = '0;
                zero_d  = 1'b1;
            end else if (tgt) begin
                state_d = DONE;
                out_d   = work_q;
                shift_d = cnt_q;
                zero_d  = 1'b0;
            end else begin
                work_d = dir_q ? work_q >> 1 : work_q << 1;
                cnt_d  = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            out_q   <= '0;
            shift_q <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            out_q   <= out_d;
            shift_q <= shift_d;
            zero_q  <= zero_d;
        end
    end

    assign busy_o  = state_q == RUN;
    assign done_o  = state_q == DONE;
    assign out_o   = out_q;
    assign shift_o = shift_q;
    assign zero_o  = zero_q;
endmodule

// File: tb/tb_shift_normalizer.sv
// tb_shift_normalizer: directed and random requests checked against an arithmetic model
// of normalization, latency and the barrel-shifter round trip.
module tb_shift_normalizer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_i = 1'b0;
    logic [7:0] in_i = '0;
    logic       dir_i = 1'b0;
    logic       busy_o, done_o, zero_o;
    logic [7:0] out_o;
    logic [2:0] shift_o;
    int total = 0;
    int bad = 0;

    shift_normalizer dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .in_i(in_i), .dir_i(dir_i),
        .busy_o(busy_o), .done_o(done_o), .out_o(out_o), .shift_o(shift_o), .zero_o(zero_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic op(input logic [7:0] v, input logic d, input bit poke);
        int k, cyc, bsy;
        logic [7:0] eo, back;
        k = 0;
        if (v != 0) while (!(d ? v[k] : v[7-k])) k++;
        eo = d ? v >> k : v << k;
        @(negedge clk);
        start_i = 1'b1; in_i = v; dir_i = d;
        @(posedge clk); #1;
        start_i = 1'b0; in_i = 8'($urandom); dir_i = 1'($urandom);
        cyc = 0; bsy = 0;
        while (!done_o && cyc < 20) begin
            if (busy_o) bsy++;
            if (poke && cyc == 1) begin start_i = 1'b1; in_i = 8'h40; end
            else if (poke && cyc == 2) start_i = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", cyc, k + 1);
        chk("busy_cycles", bsy, k + 1);
        chk("busy_at_done", int'(busy_o), 0);
        chk("out", int'(out_o), int'(eo));
        chk("shift", int'(shift_o), k);
        chk("zero", int'(zero_o), int'(v == 0));
        if (v != 0) begin
            back = d ? out_o << shift_o : out_o >> shift_o;
            chk("round_trip", int'(back), int'(v));
        end
        @(posedge clk); #1;
        chk("done_single", int'(done_o), 0);
        chk("idle_busy", int'(busy_o), 0);
        chk("out_held", int'(out_o), int'(eo));
    endtask

    initial begin
        #1;
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_out", int'(out_o), 0);
        chk("rst_shift", int'(shift_o), 0);
        chk("rst_zero", int'(zero_o), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        op(8'b10110011, 1'b0, 1'b0);
        op(8'b00010110, 1'b0, 1'b0);
        op(8'b00000001, 1'b0, 1'b0);
        op(8'b10000000, 1'b1, 1'b0);
        op(8'b10110000, 1'b1, 1'b0);
        op(8'b00000000, 1'b0, 1'b0);
        op(8'b00000000, 1'b1, 1'b0);
        op(8'b00010110, 1'b0, 1'b1);
        // reset mid-RUN: outputs clear asynchronously and done never pulses
        @(negedge clk);
        start_i = 1'b1; in_i = 8'h01; dir_i = 1'b0;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy_o), 0);
        chk("midrst_done", int'(done_o), 0);
        chk("midrst_out", int'(out_o), 0);
        chk("midrst_shift", int'(shift_o), 0);
        chk("midrst_zero", int'(zero_o), 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("midrst_no_done", int'(done_o), 0);
        end
        rst_n = 1'b1;
        op(8'b00101000, 1'b1, 1'b0);
        // start held high is re-accepted on the first IDLE edge after DONE
        @(negedge clk);
        start_i = 1'b1; in_i = 8'h80; dir_i = 1'b0;
        @(posedge clk); #1;
        chk("hold_busy_e0", int'(busy_o), 1);
        @(posedge clk); #1;
        chk("hold_done_e1", int'(done_o), 1);
        @(posedge clk); #1;
        chk("hold_idle_e2", int'(busy_o), 0);
        @(posedge clk); #1;
        chk("hold_reaccept_e3", int'(busy_o), 1);
        start_i = 1'b0;
        repeat (3) @(posedge clk);
        for (int i = 0; i < 40; i++) begin
            logic [7:0] v;
            v = (i % 8 == 0) ? 8'h00 : 8'($urandom);
            op(v, 1'($urandom), 1'($urandom_range(0, 1)) & (v[7:6] == 2'b00) & (v[1:0] == 2'b00));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
